wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 32 +++
 rtl/wb_arbiter_if.sv | 37 +++
 rtl/wb_fifo.sv | 57 +++++
 rtl/wb_arbiter.sv | 105 ++++++++++
 tb/tb_wb_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
// Latency: n/a (types and helper functions only).
// Backpressure: n/a.
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam int ENTRY_W    = REG_ADDR_W + DATA_W;

    // One register-file write port beat.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     data;
        logic                  we;
    } wr_port_t;

    // A queued mult/div result: destination plus value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     data;
    } md_entry_t;

    // One-hot register mask; register 0 never maps to a bit.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = (r != '0);
        return m;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline (master) and the write-back arbiter (slave).
// Latency: n/a (wiring only).
// Backpressure: md_ready throttles mult/div results; ALU results have none.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0]     alu_data;
    logic                  md_valid;
    logic                  md_ready;
    logic [REG_ADDR_W-1:0] md_reg;
    logic [DATA_W-1:0]     md_data;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_reg;
    logic [REG_ADDR_W-1:0] readRegA;
    logic [REG_ADDR_W-1:0] readRegB;
    logic                  hazA;
    logic                  hazB;
    logic                  alu_stall;
    logic [REG_ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0]     writeData;
    logic                  RegWrite;

    modport master (
        output alu_valid, alu_reg, alu_data, md_valid, md_reg, md_data,
               issue_valid, issue_reg, readRegA, readRegB,
        input  md_ready, hazA, hazB, alu_stall, writeReg, writeData, RegWrite
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, md_valid, md_reg, md_data,
               issue_valid, issue_reg, readRegA, readRegB,
        output md_ready, hazA, hazB, alu_stall, writeReg, writeData, RegWrite
    );

endinterface

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO, power-of-two depth, show-ahead read data.
// Latency: pushed word visible at o_rdat the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdat,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_rdat    = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage needs no reset: the cleared count hides stale words.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdat;
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU results win, queued mult/div results fill idle slots.
// Latency: selected result drives the register-file port one cycle later.
// Backpressure: md_ready drops when the result FIFO is full; alu_stall asks for a bubble.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    md_entry_t           w_head;
    logic [CW-1:0]       w_count;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_starve_hit;
    wr_port_t            w_sel;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;

    wr_port_t            r_wr;
    logic [SW-1:0]       r_starve;
    logic                r_stall;
    logic [NUM_REGS-1:0] r_pending;

    assign bus.md_ready = (w_count < CW'(FIFO_DEPTH));
    assign w_push       = bus.md_valid && bus.md_ready;
    assign w_pop        = !bus.alu_valid && !w_empty;
    assign w_starve_hit = (r_starve == SW'(STARVE_LIMIT));

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdat  ({bus.md_reg, bus.md_data}),
        .i_pop   (w_pop),
        .o_rdat  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Pick this cycle's write: ALU first, else FIFO head; destination 0 never writes.
    always_comb begin
        w_sel = '0;
        if (bus.alu_valid) begin
            w_sel.waddr = bus.alu_reg;
            w_sel.data  = bus.alu_data;
            w_sel.we    = (bus.alu_reg != '0);
        end else if (!w_empty) begin
            w_sel.waddr = w_head.waddr;
            w_sel.data  = w_head.data;
            w_sel.we    = (w_head.waddr != '0);
        end
    end

    // Register the write port so each result is presented for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wr <= '0;
        else        r_wr <= w_sel;
    end

    assign bus.writeReg  = r_wr.waddr;
    assign bus.writeData = r_wr.data;
    assign bus.RegWrite  = r_wr.we;

    // Count consecutive ALU wins over waiting mult/div results, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_starve <= '0;
        else if (bus.alu_valid && !w_empty) r_starve <= w_starve_hit ? r_starve : r_starve + 1'b1;
        else                                r_starve <= '0;
    end

    // Bubble request follows a starved or full FIFO; it pulses so the bubble's
    // effect is seen before the condition is re-evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_stall <= 1'b0;
        else        r_stall <= !r_stall && (w_starve_hit || w_full);
    end

    assign bus.alu_stall = r_stall;

    assign w_set = bus.issue_valid ? reg_onehot(bus.issue_reg) : '0;
    assign w_clr = w_pop ? reg_onehot(w_head.waddr) : '0;

    // Pending-write scoreboard; a new issue outranks a same-cycle retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= (r_pending & ~w_clr) | w_set;
    end

    assign bus.hazA = r_pending[bus.readRegA];
    assign bus.hazB = r_pending[bus.readRegB];

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model plus directed vectors.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if bus();

    wb_arbiter #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [36:0] mq[$];
    logic [31:0] m_pend   = '0;
    int          m_starve = 0;
    logic        m_stall  = 1'b0;
    logic        m_we     = 1'b0;
    logic [4:0]  m_reg    = '0;
    logic [31:0] m_data   = '0;
    int          m_pre_size;
    logic        m_nstall;
    logic [36:0] m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pend = '0; m_starve = 0; m_stall = 1'b0;
            m_we = 1'b0; m_reg = '0; m_data = '0;
        end else begin
            m_pre_size = mq.size();
            m_nstall   = !m_stall && (m_starve == STARVE_LIMIT || m_pre_size == FIFO_DEPTH);
            m_we = 1'b0; m_reg = '0; m_data = '0;
            if (bus.alu_valid) begin
                m_we   = (bus.alu_reg != 0);
                m_reg  = bus.alu_reg;
                m_data = bus.alu_data;
                if (m_pre_size != 0) m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
                else                 m_starve = 0;
            end else begin
                m_starve = 0;
                if (m_pre_size != 0) begin
                    m_e    = mq.pop_front();
                    m_reg  = m_e[36:32];
                    m_data = m_e[31:0];
                    m_we   = (m_reg != 0);
                    m_pend[m_reg] = 1'b0;
                end
            end
            if (bus.md_valid && m_pre_size < FIFO_DEPTH) mq.push_back({bus.md_reg, bus.md_data});
            if (bus.issue_valid && bus.issue_reg != 0) m_pend[bus.issue_reg] = 1'b1;
            m_stall = m_nstall;
        end
    end

    // Compare every cycle, half a period after the active edge.
    always @(negedge clk) begin
        check("RegWrite", bus.RegWrite, m_we);
        if (m_we) begin
            check("writeReg", bus.writeReg, m_reg);
            check("writeData", bus.writeData, m_data);
        end
        check("md_ready", bus.md_ready, mq.size() < FIFO_DEPTH);
        check("alu_stall", bus.alu_stall, m_stall);
        check("hazA", bus.hazA, m_pend[bus.readRegA]);
        check("hazB", bus.hazB, m_pend[bus.readRegB]);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.md_valid = 1'b0;  bus.md_reg = '0;  bus.md_data = '0;
        bus.issue_valid = 1'b0; bus.issue_reg = '0;
        bus.readRegA = '0; bus.readRegB = '0;
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        repeat (2) tick();
        check("rst_md_ready", bus.md_ready, 1);
        check("rst_RegWrite", bus.RegWrite, 0);
        check("rst_writeReg", bus.writeReg, 0);
        check("rst_writeData", bus.writeData, 0);
        check("rst_alu_stall", bus.alu_stall, 0);
        check("rst_hazA", bus.hazA, 0);
        rst_n = 1'b1;
        tick();

        // ALU only
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'h944EB;
        tick();
        check("alu_we", bus.RegWrite, 1);
        check("alu_reg", bus.writeReg, 5);
        check("alu_data", bus.writeData, 32'h944EB);
        idle();
        tick();
        check("alu_one_cycle", bus.RegWrite, 0);

        // Priority: ALU beats a waiting FIFO entry
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd7;
        tick();
        idle(); bus.md_valid = 1'b1; bus.md_reg = 5'd7; bus.md_data = 32'h964EA;
        tick();
        idle(); bus.alu_valid = 1'b1; bus.alu_reg = 5'd4; bus.alu_data = 32'h0E311; bus.readRegA = 5'd7;
        tick();
        check("prio_alu_reg", bus.writeReg, 4);
        check("prio_alu_data", bus.writeData, 32'h0E311);
        check("prio_haz7_held", bus.hazA, 1);
        idle(); bus.readRegA = 5'd7;
        tick();
        check("prio_md_we", bus.RegWrite, 1);
        check("prio_md_reg", bus.writeReg, 7);
        check("prio_md_data", bus.writeData, 32'h964EA);
        check("prio_haz7_clear", bus.hazA, 0);

        // Fill the FIFO under continuous ALU traffic
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1; bus.alu_reg = 5'd1; bus.alu_data = i;
            bus.md_valid = 1'b1; bus.md_reg = 5'(10 + i); bus.md_data = 32'hA0 + i;
            tick();
        end
        check("full_md_ready", bus.md_ready, 0);
        check("full_stall_early", bus.alu_stall, 0);
        bus.md_valid = 1'b0;
        tick();
        check("full_stall", bus.alu_stall, 1);
        idle();
        tick();
        check("bubble_we", bus.RegWrite, 1);
        check("bubble_reg", bus.writeReg, 10);
        check("bubble_data", bus.writeData, 32'hA0);
        check("bubble_md_ready", bus.md_ready, 1);
        check("bubble_stall_off", bus.alu_stall, 0);
        repeat (3) tick();
        check("drain_reg", bus.writeReg, 13);
        check("drain_data", bus.writeData, 32'hA3);
        tick();

        // Scoreboard set/clear
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd8; bus.readRegA = 5'd8; bus.readRegB = 5'd8;
        tick();
        check("sb_hazA_set", bus.hazA, 1);
        check("sb_hazB_set", bus.hazB, 1);
        idle(); bus.alu_valid = 1'b1; bus.alu_reg = 5'd2; bus.alu_data = 32'd5;
        bus.md_valid = 1'b1; bus.md_reg = 5'd8; bus.md_data = 32'h88; bus.readRegA = 5'd8;
        tick();
        check("sb_hazA_queued", bus.hazA, 1);
        idle(); bus.issue_valid = 1'b1; bus.issue_reg = 5'd8; bus.readRegA = 5'd8;
        tick();
        check("sb_pop_reg", bus.writeReg, 8);
        check("sb_pop_data", bus.writeData, 32'h88);
        check("sb_setclr_hazA", bus.hazA, 1);
        idle(); bus.md_valid = 1'b1; bus.md_reg = 5'd8; bus.md_data = 32'h99; bus.readRegA = 5'd8;
        tick();
        idle(); bus.readRegA = 5'd8;
        tick();
        check("sb_pop2_data", bus.writeData, 32'h99);
        check("sb_hazA_clear", bus.hazA, 0);

        // Register 0
        idle(); bus.md_valid = 1'b1; bus.md_reg = 5'd0; bus.md_data = 32'hDEAD;
        tick();
        idle(); bus.md_valid = 1'b1; bus.md_reg = 5'd9; bus.md_data = 32'h77;
        tick();
        check("r0_no_write", bus.RegWrite, 0);
        idle();
        tick();
        check("r0_next_we", bus.RegWrite, 1);
        check("r0_next_reg", bus.writeReg, 9);
        bus.issue_valid = 1'b1; bus.issue_reg = 5'd0; bus.readRegA = 5'd0;
        tick();
        check("r0_hazA", bus.hazA, 0);

        // Reset with three queued entries
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = i;
            bus.md_valid = 1'b1; bus.md_reg = 5'(20 + i); bus.md_data = 32'h200 + i;
            bus.issue_valid = 1'b1; bus.issue_reg = 5'(20 + i);
            bus.readRegA = 5'd20; bus.readRegB = 5'd21;
            tick();
        end
        check("pre_rst_hazA", bus.hazA, 1);
        idle(); bus.readRegA = 5'd20; bus.readRegB = 5'd21;
        rst_n = 1'b0;
        #2;
        check("mid_rst_md_ready", bus.md_ready, 1);
        check("mid_rst_RegWrite", bus.RegWrite, 0);
        check("mid_rst_hazA", bus.hazA, 0);
        check("mid_rst_hazB", bus.hazB, 0);
        check("mid_rst_stall", bus.alu_stall, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_no_write", bus.RegWrite, 0);
        end
        bus.md_valid = 1'b1; bus.md_reg = 5'd3; bus.md_data = 32'h1234;
        tick();
        idle();
        tick();
        check("post_rst_we", bus.RegWrite, 1);
        check("post_rst_reg", bus.writeReg, 3);
        check("post_rst_data", bus.writeData, 32'h1234);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
